mcp3002_follower: RTL and testbench

Synthesizable SPI follower that emulates the MCP3002 10-bit ADC on the CLK_50MHz domain. It decodes the start/SGL/ODD/MSBF command shifted in by an SPI leader and returns the null bit plus the conversion result on Dout. Channel values come from fabric registers. The block serves as an in-FPGA loopback target for bring-up and regression of the data-logger ADC leader without the physical chip.

---
 rtl/mcp3002_follower_pkg.sv | 24 ++
 rtl/mcp3002_follower_spi_sync_edge.sv | 54 +++++
 rtl/mcp3002_follower.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mcp3002_follower.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcp3002_follower_pkg.sv
// Shared definitions for the MCP3002 follower.
// Contents: FSM state encoding, bit positions of the four command bits
// inside the captured command word, and the default result width.
package mcp3002_follower_pkg;

  localparam int DEFAULT_DATA_BITS = 10;

  // Bit positions inside the 4-bit command word {START, SGL, ODD, MSBF}.
  localparam int CMD_START = 3;
  localparam int CMD_SGL   = 2;
  localparam int CMD_ODD   = 1;
  localparam int CMD_MSBF  = 0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_CONFIG     = 3'd2,
    ST_NULL_BIT   = 3'd3,
    ST_DATA_MSB   = 3'd4,
    ST_DATA_LSB   = 3'd5,
    ST_TRAIL      = 3'd6
  } state_t;

endpackage

// File: rtl/mcp3002_follower_spi_sync_edge.sv
// Multi-bit synchronizer with rise/fall strobes on bit 0.
// Ports:
//   i_clk, i_rst : system clock, asynchronous active-high reset
//   i_async      : WIDTH asynchronous inputs
//   o_sync       : synchronized copies after STAGES flops
//   o_rise/o_fall: registered one-cycle strobes for edges of o_sync[0]
// The strobes lag the pin by STAGES+1 cycles. Only bit 0 gets edge
// detection; the other bits are plain synchronized levels.
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic             o_rise,
  output logic             o_fall
);

  logic [WIDTH-1:0] r_chain [STAGES];
  logic             r_prev;

  // Synchronizer chain; everything resets low so a line held low through
  // reset never looks like a falling edge afterwards.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_chain[i] <= '0;
      end
    end else begin
      r_chain[0] <= i_async;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_sync = r_chain[STAGES-1];

  // Edge strobes on the synchronized bit 0, registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_prev <= o_sync[0];
      o_rise <= o_sync[0] & ~r_prev;
      o_fall <= ~o_sync[0] & r_prev;
    end
  end

endmodule

// File: rtl/mcp3002_follower.sv
// MCP3002 10-bit ADC emulator acting as an SPI follower on CLK_50MHz.
// Ports:
//   CLK_50MHz, RESET        : system clock, async active-high reset
//   CLKsample, CS, Din      : SPI leader signals (asynchronous)
//   ch0_value, ch1_value    : channel levels, sampled at the null bit
//   Dout, Dout_en           : result bit and its tri-state enable
//   conv_done               : pulse when the last result bit is driven
//   conv_channel/conv_single: ODD/SGL of the last accepted command
//   conv_count              : completed conversions, wraps at 16 bits
//   frame_error             : pulse when CS rises mid-frame
module mcp3002_follower
  import mcp3002_follower_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK_50MHz,
  input  logic                 RESET,
  input  logic                 CLKsample,
  input  logic                 CS,
  input  logic                 Din,
  input  logic [DATA_BITS-1:0] ch0_value,
  input  logic [DATA_BITS-1:0] ch1_value,
  output logic                 Dout,
  output logic                 Dout_en,
  output logic                 conv_done,
  output logic                 conv_channel,
  output logic                 conv_single,
  output logic [15:0]          conv_count,
  output logic                 frame_error
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

  logic [2:0]           w_sync;
  logic                 w_sclk_rise;
  logic                 w_sclk_fall;
  logic                 w_cs_s;
  logic                 w_din_s;
  logic                 w_cs_fall;
  logic                 w_rise;
  logic                 w_fall;

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_cmd;
  logic [3:0]           w_cmd_next;
  logic [1:0]           r_cfg_cnt;
  logic [1:0]           w_cfg_next;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_idx_next;
  logic [DATA_BITS-1:0] r_result;
  logic [DATA_BITS-1:0] w_result_next;
  logic [DATA_BITS-1:0] w_result;
  logic [DATA_BITS:0]   w_diff;
  logic                 r_cs_prev;
  logic                 r_dout;
  logic                 w_dout_next;
  logic                 r_dout_en;
  logic                 w_en_next;
  logic                 r_conv_done;
  logic                 w_done_next;
  logic                 r_frame_error;
  logic                 w_ferr_next;
  logic                 r_conv_channel;
  logic                 w_chan_next;
  logic                 r_conv_single;
  logic                 w_single_next;
  logic [15:0]          r_conv_count;
  logic [15:0]          w_count_next;

  // Bit 0 = CLKsample (edge strobes), bit 1 = CS, bit 2 = Din.
  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (3)
  ) u_sync (
    .i_clk   (CLK_50MHz),
    .i_rst   (RESET),
    .i_async ({Din, CS, CLKsample}),
    .o_sync  (w_sync),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  assign w_cs_s    = w_sync[1];
  assign w_din_s   = w_sync[2];
  assign w_cs_fall = r_cs_prev & ~w_cs_s;
  assign w_rise    = w_sclk_rise & ~w_cs_s;
  assign w_fall    = w_sclk_fall & ~w_cs_s;

  // Conversion result; differential modes subtract one bit wider and
  // clamp to zero when the sign bit is set.
  always_comb begin
    w_diff   = '0;
    w_result = '0;
    if (r_cmd[CMD_SGL]) begin
      w_result = r_cmd[CMD_ODD] ? ch1_value : ch0_value;
    end else begin
      if (r_cmd[CMD_ODD]) begin
        w_diff = {1'b0, ch1_value} - {1'b0, ch0_value};
      end else begin
        w_diff = {1'b0, ch0_value} - {1'b0, ch1_value};
      end
      w_result = w_diff[DATA_BITS] ? '0 : w_diff[DATA_BITS-1:0];
    end
  end

  // Next-state and next-output logic; a CS abort overrides every state.
  always_comb begin
    w_state_next  = r_state;
    w_cmd_next    = r_cmd;
    w_cfg_next    = r_cfg_cnt;
    w_idx_next    = r_bit_idx;
    w_result_next = r_result;
    w_dout_next   = r_dout;
    w_en_next     = r_dout_en;
    w_done_next   = 1'b0;
    w_ferr_next   = 1'b0;
    w_chan_next   = r_conv_channel;
    w_single_next = r_conv_single;
    w_count_next  = r_conv_count;

    if (w_cs_s) begin
      w_state_next = ST_IDLE;
      w_dout_next  = 1'b0;
      w_en_next    = 1'b0;
      case (r_state)
        ST_CONFIG, ST_NULL_BIT, ST_DATA_MSB, ST_DATA_LSB: w_ferr_next = 1'b1;
        default:                                          w_ferr_next = 1'b0;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            w_state_next = ST_WAIT_START;
            w_cmd_next   = 4'b0000;
            w_cfg_next   = 2'd0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_WAIT_START: begin
          if (w_rise && w_din_s) begin
            w_state_next          = ST_CONFIG;
            w_cmd_next[CMD_START] = 1'b1;
            w_cfg_next            = 2'd0;
          end else begin
            w_state_next = ST_WAIT_START;
          end
        end
        ST_CONFIG: begin
          if (w_rise) begin
            case (r_cfg_cnt)
              2'd0: begin
                w_cmd_next[CMD_SGL] = w_din_s;
                w_cfg_next          = 2'd1;
              end
              2'd1: begin
                w_cmd_next[CMD_ODD] = w_din_s;
                w_cfg_next          = 2'd2;
              end
              default: begin
                w_cmd_next[CMD_MSBF] = w_din_s;
                w_cfg_next           = 2'd0;
                w_state_next         = ST_NULL_BIT;
                w_chan_next          = r_cmd[CMD_ODD];
                w_single_next        = r_cmd[CMD_SGL];
              end
            endcase
          end else begin
            w_state_next = ST_CONFIG;
          end
        end
        ST_NULL_BIT: begin
          if (w_fall) begin
            w_result_next = w_result;
            w_dout_next   = 1'b0;
            w_en_next     = 1'b1;
            w_idx_next    = IDX_MAX;
            w_state_next  = ST_DATA_MSB;
          end else begin
            w_state_next = ST_NULL_BIT;
          end
        end
        ST_DATA_MSB: begin
          if (w_fall) begin
            w_dout_next = r_result[r_bit_idx];
            if (r_bit_idx == '0) begin
              if (r_cmd[CMD_MSBF]) begin
                w_done_next  = 1'b1;
                w_count_next = r_conv_count + 16'd1;
                w_state_next = ST_TRAIL;
              end else begin
                // LSB-first tail starts at bit 1; bit 0 was just sent.
                w_idx_next   = IDX_W'(1'b1);
                w_state_next = ST_DATA_LSB;
              end
            end else begin
              w_idx_next = r_bit_idx - IDX_W'(1'b1);
            end
          end else begin
            w_state_next = ST_DATA_MSB;
          end
        end
        ST_DATA_LSB: begin
          if (w_fall) begin
            w_dout_next = r_result[r_bit_idx];
            if (r_bit_idx == IDX_MAX) begin
              w_done_next  = 1'b1;
              w_count_next = r_conv_count + 16'd1;
              w_state_next = ST_TRAIL;
            end else begin
              w_idx_next = r_bit_idx + IDX_W'(1'b1);
            end
          end else begin
            w_state_next = ST_DATA_LSB;
          end
        end
        ST_TRAIL: begin
          if (w_fall) begin
            w_dout_next = 1'b0;
          end else begin
            w_dout_next = r_dout;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_dout_next  = 1'b0;
          w_en_next    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK_50MHz or posedge RESET) begin
    if (RESET) begin
      r_state        <= ST_IDLE;
      r_cmd          <= 4'b0000;
      r_cfg_cnt      <= 2'd0;
      r_bit_idx      <= '0;
      r_result       <= '0;
      r_cs_prev      <= 1'b0;
      r_dout         <= 1'b0;
      r_dout_en      <= 1'b0;
      r_conv_done    <= 1'b0;
      r_frame_error  <= 1'b0;
      r_conv_channel <= 1'b0;
      r_conv_single  <= 1'b0;
      r_conv_count   <= 16'd0;
    end else begin
      r_state        <= w_state_next;
      r_cmd          <= w_cmd_next;
      r_cfg_cnt      <= w_cfg_next;
      r_bit_idx      <= w_idx_next;
      r_result       <= w_result_next;
      r_cs_prev      <= w_cs_s;
      r_dout         <= w_dout_next;
      r_dout_en      <= w_en_next;
      r_conv_done    <= w_done_next;
      r_frame_error  <= w_ferr_next;
      r_conv_channel <= w_chan_next;
      r_conv_single  <= w_single_next;
      r_conv_count   <= w_count_next;
    end
  end

  assign Dout         = r_dout;
  assign Dout_en      = r_dout_en;
  assign conv_done    = r_conv_done;
  assign conv_channel = r_conv_channel;
  assign conv_single  = r_conv_single;
  assign conv_count   = r_conv_count;
  assign frame_error  = r_frame_error;

endmodule

// File: tb/tb_mcp3002_follower.sv
// Self-checking bench for mcp3002_follower: table-driven frames with a
// scoreboard of expected Dout bits, plus abort, wrap and reset sequences.
module tb_mcp3002_follower;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       cs;
  logic       din;
  logic [9:0] ch0;
  logic [9:0] ch1;
  logic       dout;
  logic       dout_en;
  logic       conv_done;
  logic       conv_channel;
  logic       conv_single;
  logic [15:0] conv_count;
  logic       frame_error;

  mcp3002_follower dut (
    .CLK_50MHz    (clk),
    .RESET        (rst),
    .CLKsample    (sclk),
    .CS           (cs),
    .Din          (din),
    .ch0_value    (ch0),
    .ch1_value    (ch1),
    .Dout         (dout),
    .Dout_en      (dout_en),
    .conv_done    (conv_done),
    .conv_channel (conv_channel),
    .conv_single  (conv_single),
    .conv_count   (conv_count),
    .frame_error  (frame_error)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic       sgl;
    logic       odd;
    logic       msbf;
    logic [9:0] ch0;
    logic [9:0] ch1;
    int         lead;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [8];
  logic sb_q [$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_done = 0;
  int   n_ferr = 0;
  logic [15:0] exp_count = 16'd0;

  // Pulse counters for the one-cycle status outputs.
  always @(negedge clk) begin
    if (conv_done === 1'b1) n_done++;
    if (frame_error === 1'b1) n_ferr++;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " Dout"}, {31'd0, dout}, 32'd0);
    check({tag, " Dout_en"}, {31'd0, dout_en}, 32'd0);
    check({tag, " conv_done"}, {31'd0, conv_done}, 32'd0);
    check({tag, " conv_channel"}, {31'd0, conv_channel}, 32'd0);
    check({tag, " conv_single"}, {31'd0, conv_single}, 32'd0);
    check({tag, " conv_count"}, {16'd0, conv_count}, 32'd0);
    check({tag, " frame_error"}, {31'd0, frame_error}, 32'd0);
  endtask

  // One SCLK period: Din set, low phase, sample Dout just before rise,
  // high phase, then fall.
  task automatic sclk_pulse(input logic d, output logic d_s, output logic en_s);
    din = d;
    wait_cycles(9);
    d_s  = dout;
    en_s = dout_en;
    sclk = 1'b1;
    wait_cycles(9);
    sclk = 1'b0;
  endtask

  function automatic int frame_len(input int v);
    return vecs[v].lead + 4 + 1 + (vecs[v].msbf ? 10 : 19);
  endfunction

  // Lowers CS, pushes the expected Dout stream, issues n_pulses clocks and
  // compares every sampled bit against the scoreboard. CS stays low.
  task automatic drive_frame(input int v, input int n_pulses);
    logic [9:0] e;
    logic       cmd_bit;
    logic       d_s;
    logic       en_s;
    logic       exp_bit;
    int         nlead;
    e     = vecs[v].exp;
    nlead = vecs[v].lead;
    ch0   = vecs[v].ch0;
    ch1   = vecs[v].ch1;
    sb_q.push_back(1'b0);
    for (int b = 9; b >= 0; b--) sb_q.push_back(e[b]);
    if (!vecs[v].msbf) begin
      for (int b = 1; b <= 9; b++) sb_q.push_back(e[b]);
    end
    cs = 1'b0;
    wait_cycles(8);
    for (int i = 0; i < n_pulses; i++) begin
      if (i < nlead)          cmd_bit = 1'b0;
      else if (i == nlead)    cmd_bit = 1'b1;
      else if (i == nlead + 1) cmd_bit = vecs[v].sgl;
      else if (i == nlead + 2) cmd_bit = vecs[v].odd;
      else if (i == nlead + 3) cmd_bit = vecs[v].msbf;
      else                    cmd_bit = 1'b0;
      sclk_pulse(cmd_bit, d_s, en_s);
      if (i >= nlead + 4) begin
        if (sb_q.size() == 0) begin
          check($sformatf("vec%0d scoreboard underflow", v), 32'd1, 32'd0);
        end else begin
          exp_bit = sb_q.pop_front();
          check($sformatf("vec%0d Dout bit %0d", v, i - nlead - 4), {31'd0, d_s}, {31'd0, exp_bit});
          check($sformatf("vec%0d Dout_en bit %0d", v, i - nlead - 4), {31'd0, en_s}, 32'd1);
        end
      end
    end
  endtask

  task automatic run_frame(input int v);
    int d0;
    int f0;
    d0 = n_done;
    f0 = n_ferr;
    drive_frame(v, frame_len(v));
    check($sformatf("vec%0d scoreboard empty", v), sb_q.size(), 32'd0);
    sb_q.delete();
    wait_cycles(9);
    cs = 1'b1;
    wait_cycles(10);
    exp_count = exp_count + 16'd1;
    check($sformatf("vec%0d conv_done pulses", v), n_done - d0, 32'd1);
    check($sformatf("vec%0d frame_error pulses", v), n_ferr - f0, 32'd0);
    check($sformatf("vec%0d conv_channel", v), {31'd0, conv_channel}, {31'd0, vecs[v].odd});
    check($sformatf("vec%0d conv_single", v), {31'd0, conv_single}, {31'd0, vecs[v].sgl});
    check($sformatf("vec%0d conv_count", v), {16'd0, conv_count}, {16'd0, exp_count});
    check($sformatf("vec%0d Dout_en after CS", v), {31'd0, dout_en}, 32'd0);
  endtask

  initial begin
    int d0;
    int f0;
    //         sgl   odd   msbf  ch0     ch1     lead exp
    vecs[0] = '{1'b1, 1'b1, 1'b1, 10'h155, 10'h2A5, 0, 10'h2A5};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 10'h301, 10'h0AA, 0, 10'h301};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 10'h010, 10'h020, 0, 10'h000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 10'h010, 10'h020, 0, 10'h010};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 10'h155, 10'h2A5, 3, 10'h2A5};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 10'h3FF, 10'h001, 1, 10'h3FE};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 10'h3FF, 10'h000, 0, 10'h3FF};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 10'h200, 10'h200, 0, 10'h000};

    rst  = 1'b1;
    cs   = 1'b1;
    sclk = 1'b0;
    din  = 1'b0;
    ch0  = 10'h000;
    ch1  = 10'h000;
    wait_cycles(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cycles(10);

    for (int v = 0; v < 8; v++) run_frame(v);

    // Abort after four data bits in DATA_MSB.
    d0 = n_done;
    f0 = n_ferr;
    drive_frame(0, 8);
    sb_q.delete();
    wait_cycles(9);
    cs = 1'b1;
    wait_cycles(10);
    check("abort frame_error pulses", n_ferr - f0, 32'd1);
    check("abort conv_done pulses", n_done - d0, 32'd0);
    check("abort Dout_en", {31'd0, dout_en}, 32'd0);
    check("abort Dout", {31'd0, dout}, 32'd0);
    check("abort conv_count", {16'd0, conv_count}, {16'd0, exp_count});
    run_frame(3);

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.r_conv_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_conv_count;
    @(negedge clk);
    exp_count = 16'hFFFF;
    check("wrap preload", {16'd0, conv_count}, 32'h0000FFFF);
    run_frame(0);
    check("wrap to zero", {16'd0, conv_count}, 32'd0);

    // Reset asserted mid-DATA_MSB clears outputs asynchronously.
    drive_frame(0, 7);
    sb_q.delete();
    wait_cycles(6);
    check("pre-reset Dout_en", {31'd0, dout_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("mid-frame reset");
    cs = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(10);
    exp_count = 16'd0;
    run_frame(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
